// File: rtl/fetch_branch_ctrl_pkg.sv
// Shared definitions for the fetch/branch controller: FSM encoding,
// opcode constants and instruction field accessors.
package fetch_branch_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_ERROR  = 3'd4
    } fbc_state_e;

    localparam logic [1:0] OP_BEQ = 2'b11;

    localparam int INST_W = 8;
    localparam int OP_HI  = 7;
    localparam int OP_LO  = 6;
    localparam int RS_HI  = 5;
    localparam int RS_LO  = 4;
    localparam int RT_HI  = 3;
    localparam int RT_LO  = 2;

    function automatic logic [1:0] inst_op(input logic [INST_W-1:0] inst);
        return inst[OP_HI:OP_LO];
    endfunction

    function automatic logic [1:0] inst_rs(input logic [INST_W-1:0] inst);
        return inst[RS_HI:RS_LO];
    endfunction

    function automatic logic [1:0] inst_rt(input logic [INST_W-1:0] inst);
        return inst[RT_HI:RT_LO];
    endfunction

endpackage

// File: rtl/fetch_branch_ctrl_sign_ext.sv
// Combinational sign extension of the branch immediate to an 8-bit offset.
module sign_ext_unit #(
    parameter int IMM_W = 2
) (
    input  logic [IMM_W-1:0] imm,
    output logic [7:0]       ext
);

    assign ext = {{(8 - IMM_W){imm[IMM_W-1]}}, imm};

endmodule

// File: rtl/fetch_branch_ctrl.sv
// Fetch/decode/issue controller: fetches one instruction byte, compares the
// selected registers and strobes a registered branch with its offset.
module fetch_branch_ctrl #(
    parameter int IMEM_TIMEOUT = 15,
    parameter int IMM_W        = 2
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [7:0] address,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic       imem_ack,
    input  logic [7:0] imem_data,
    input  logic [7:0] rs_data,
    input  logic [7:0] rt_data,
    output logic [1:0] rs_sel,
    output logic [1:0] rt_sel,
    output logic       branch,
    output logic [7:0] sign_extended,
    output logic       pc_hold,
    output logic       fetch_err
);
    import fetch_branch_ctrl_pkg::*;

    localparam int CNT_W = $clog2(IMEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMEM_TIMEOUT - 1);

    fbc_state_e       state_q, state_d;
    logic             started_q, started_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       inst_q, inst_d;
    logic             imem_req_q, imem_req_d;
    logic [7:0]       imem_addr_q, imem_addr_d;
    logic             branch_q, branch_d;
    logic [7:0]       sext_q, sext_d;
    logic             pc_hold_q, pc_hold_d;
    logic             fetch_err_q, fetch_err_d;
    logic [7:0]       ext_s;

    sign_ext_unit #(.IMM_W(IMM_W)) u_sign_ext (
        .imm (inst_q[IMM_W-1:0]),
        .ext (ext_s)
    );

    // Next-state logic; started_q keeps IDLE for one full cycle after reset release.
    always_comb begin
        state_d     = state_q;
        started_d   = 1'b1;
        cnt_d       = cnt_q;
        inst_d      = inst_q;
        fetch_err_d = fetch_err_q;
        case (state_q)
            ST_IDLE: begin
                if (started_q) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                // Ack wins over the timeout on the final allowed cycle.
                if (imem_ack) begin
                    inst_d  = imem_data;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_DECODE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d       = {CNT_W{1'b0}};
                    fetch_err_d = 1'b1;
                    state_d     = ST_ERROR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DECODE: state_d = ST_ISSUE;
            ST_ISSUE:  state_d = ST_FETCH;
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Registered outputs are computed from the next state so they line up with it.
    always_comb begin
        imem_req_d  = (state_d == ST_FETCH);
        pc_hold_d   = (state_d != ST_ISSUE);
        imem_addr_d = imem_addr_q;
        branch_d    = 1'b0;
        sext_d      = 8'h00;
        if ((state_d == ST_FETCH) && (state_q != ST_FETCH)) begin
            imem_addr_d = address;
        end else begin
            imem_addr_d = imem_addr_q;
        end
        if ((state_q == ST_DECODE) && (inst_op(inst_q) == OP_BEQ) && (rs_data == rt_data)) begin
            branch_d = 1'b1;
            sext_d   = ext_s;
        end else begin
            branch_d = 1'b0;
            sext_d   = 8'h00;
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            started_q   <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            inst_q      <= 8'h00;
            imem_req_q  <= 1'b0;
            imem_addr_q <= 8'h00;
            branch_q    <= 1'b0;
            sext_q      <= 8'h00;
            pc_hold_q   <= 1'b1;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            started_q   <= started_d;
            cnt_q       <= cnt_d;
            inst_q      <= inst_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            branch_q    <= branch_d;
            sext_q      <= sext_d;
            pc_hold_q   <= pc_hold_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign imem_req      = imem_req_q;
    assign imem_addr     = imem_addr_q;
    assign rs_sel        = inst_rs(inst_q);
    assign rt_sel        = inst_rt(inst_q);
    assign branch        = branch_q;
    assign sign_extended = sext_q;
    assign pc_hold       = pc_hold_q;
    assign fetch_err     = fetch_err_q;

endmodule

// File: tb/tb_fetch_branch_ctrl.sv
// Directed self-checking bench for fetch_branch_ctrl.
module tb_fetch_branch_ctrl;

    logic       CLK;
    logic       RESET_N;
    logic [7:0] address;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic [7:0] rs_data;
    logic [7:0] rt_data;
    logic [1:0] rs_sel;
    logic [1:0] rt_sel;
    logic       branch;
    logic [7:0] sign_extended;
    logic       pc_hold;
    logic       fetch_err;

    int total = 0;
    int bad   = 0;

    fetch_branch_ctrl #(.IMEM_TIMEOUT(15), .IMM_W(2)) dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .address       (address),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .rs_sel        (rs_sel),
        .rt_sel        (rt_sel),
        .branch        (branch),
        .sign_extended (sign_extended),
        .pc_hold       (pc_hold),
        .fetch_err     (fetch_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},    {7'd0, imem_req},  8'h00);
        chk({tag, "_addr"},   imem_addr,         8'h00);
        chk({tag, "_br"},     {7'd0, branch},    8'h00);
        chk({tag, "_sext"},   sign_extended,     8'h00);
        chk({tag, "_hold"},   {7'd0, pc_hold},   8'h01);
        chk({tag, "_err"},    {7'd0, fetch_err}, 8'h00);
        chk({tag, "_rs_sel"}, {6'd0, rs_sel},    8'h00);
        chk({tag, "_rt_sel"}, {6'd0, rt_sel},    8'h00);
    endtask

    initial begin
        RESET_N   = 1'b1;
        address   = 8'h00;
        imem_ack  = 1'b0;
        imem_data = 8'h00;
        rs_data   = 8'h00;
        rt_data   = 8'h00;
        #2 RESET_N = 1'b0;
        #1 chk_reset_vals("rst");

        // Reset release: one IDLE cycle, FETCH from the second posedge.
        @(negedge CLK);
        RESET_N = 1'b1;
        address = 8'h10;
        tick();
        chk("idle_req",  {7'd0, imem_req}, 8'h00);
        chk("idle_hold", {7'd0, pc_hold},  8'h01);
        tick();
        chk("fetch1_req",  {7'd0, imem_req}, 8'h01);
        chk("fetch1_addr", imem_addr,        8'h10);

        // Taken BEQ, imm 2'b10.
        @(negedge CLK);
        imem_ack  = 1'b1;
        imem_data = 8'hC6;
        rs_data   = 8'h33;
        rt_data   = 8'h33;
        tick();
        chk("dec1_req",    {7'd0, imem_req}, 8'h00);
        chk("dec1_rs_sel", {6'd0, rs_sel},   8'h00);
        chk("dec1_rt_sel", {6'd0, rt_sel},   8'h01);
        chk("dec1_br",     {7'd0, branch},   8'h00);
        chk("dec1_hold",   {7'd0, pc_hold},  8'h01);
        @(negedge CLK);
        imem_ack = 1'b0;
        tick();
        chk("iss1_br",   {7'd0, branch},  8'h01);
        chk("iss1_sext", sign_extended,   8'hFE);
        chk("iss1_hold", {7'd0, pc_hold}, 8'h00);
        @(negedge CLK);
        address = 8'h20;
        tick();
        chk("fetch2_br",   {7'd0, branch},   8'h00);
        chk("fetch2_sext", sign_extended,    8'h00);
        chk("fetch2_hold", {7'd0, pc_hold},  8'h01);
        chk("fetch2_req",  {7'd0, imem_req}, 8'h01);
        chk("fetch2_addr", imem_addr,        8'h20);

        // Not-taken BEQ: registers differ.
        @(negedge CLK);
        address   = 8'h21;
        imem_ack  = 1'b1;
        imem_data = 8'hC6;
        rs_data   = 8'h05;
        rt_data   = 8'h06;
        tick();
        chk("dec2_addr_held", imem_addr, 8'h20);
        @(negedge CLK);
        imem_ack = 1'b0;
        tick();
        chk("iss2_br",   {7'd0, branch},  8'h00);
        chk("iss2_sext", sign_extended,   8'h00);
        chk("iss2_hold", {7'd0, pc_hold}, 8'h00);
        tick();
        chk("fetch3_req", {7'd0, imem_req}, 8'h01);

        // Non-branch op, ack held high: ISSUE once every three cycles.
        @(negedge CLK);
        imem_ack  = 1'b1;
        imem_data = 8'h41;
        rs_data   = 8'h07;
        rt_data   = 8'h07;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("b2b_hold_%0d", i), {7'd0, pc_hold}, ((i % 3) == 1) ? 8'h01 - 8'h01 : 8'h01);
            chk($sformatf("b2b_br_%0d", i),   {7'd0, branch},  8'h00);
        end

        // Ack on the 15th FETCH cycle: no error.
        @(negedge CLK);
        imem_ack = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            chk($sformatf("late_req_%0d", i), {7'd0, imem_req},  8'h01);
            chk($sformatf("late_err_%0d", i), {7'd0, fetch_err}, 8'h00);
        end
        @(negedge CLK);
        imem_ack  = 1'b1;
        imem_data = 8'h2C;
        tick();
        chk("late_dec_err",    {7'd0, fetch_err}, 8'h00);
        chk("late_dec_req",    {7'd0, imem_req},  8'h00);
        chk("late_dec_rs_sel", {6'd0, rs_sel},    8'h02);
        chk("late_dec_rt_sel", {6'd0, rt_sel},    8'h03);
        @(negedge CLK);
        imem_ack = 1'b0;
        tick();
        chk("late_iss_hold", {7'd0, pc_hold}, 8'h00);
        tick();
        chk("to_fetch_req", {7'd0, imem_req}, 8'h01);

        // No ack for 15 FETCH cycles: ERROR.
        for (int i = 0; i < 14; i++) begin
            tick();
            chk($sformatf("to_err_%0d", i), {7'd0, fetch_err}, 8'h00);
        end
        tick();
        chk("err_flag", {7'd0, fetch_err}, 8'h01);
        chk("err_req",  {7'd0, imem_req},  8'h00);
        chk("err_hold", {7'd0, pc_hold},   8'h01);
        chk("err_br",   {7'd0, branch},    8'h00);
        @(negedge CLK);
        imem_ack = 1'b1;
        tick();
        tick();
        chk("err_stay_flag", {7'd0, fetch_err}, 8'h01);
        chk("err_stay_req",  {7'd0, imem_req},  8'h00);
        @(negedge CLK);
        imem_ack = 1'b0;
        RESET_N  = 1'b0;
        #1 chk_reset_vals("rst_err");

        // Reset mid-FETCH with an ack pending.
        @(negedge CLK);
        RESET_N = 1'b1;
        address = 8'h55;
        tick();
        tick();
        chk("fetch4_addr", imem_addr, 8'h55);
        @(negedge CLK);
        imem_ack  = 1'b1;
        imem_data = 8'h2C;
        tick();
        @(negedge CLK);
        imem_ack = 1'b0;
        tick();
        tick();
        chk("fetch5_req",    {7'd0, imem_req}, 8'h01);
        chk("fetch5_rs_sel", {6'd0, rs_sel},   8'h02);
        #2;
        RESET_N   = 1'b0;
        imem_ack  = 1'b1;
        imem_data = 8'hC6;
        #1 chk_reset_vals("rst_mid");
        tick();
        tick();
        chk("rst_hold_req", {7'd0, imem_req}, 8'h00);
        @(negedge CLK);
        RESET_N = 1'b1;
        tick();
        chk("post_rst_req",    {7'd0, imem_req}, 8'h00);
        chk("post_rst_rs_sel", {6'd0, rs_sel},   8'h00);
        chk("post_rst_rt_sel", {6'd0, rt_sel},   8'h00);
        @(negedge CLK);
        imem_ack = 1'b0;
        tick();
        chk("post_rst_fetch_req", {7'd0, imem_req}, 8'h01);
        chk("post_rst_rt_keep",   {6'd0, rt_sel},   8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
